// File: rtl/seq_divider_32.sv
// Sequential restoring divider: one quotient bit per cycle, signed or unsigned,
// with fixed latency, divide-by-zero and signed-overflow flags.
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] dvd_orig_reg;
  logic [WIDTH-1:0] work_reg;   // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             neg_q_reg, neg_r_reg, zero_reg, ovf_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             div_by_zero_reg, overflow_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;

  // Partial remainder can exceed WIDTH bits after the shift, so the borrow
  // is taken from one bit above the shifted value.
  assign shifted         = {rem_reg, work_reg[WIDTH-1]};
  assign {borrow, diff}  = {1'b0, shifted} - {2'b00, dvs_reg};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      dvd_orig_reg    <= '0;
      work_reg        <= '0;
      dvs_reg         <= '0;
      rem_reg         <= '0;
      neg_q_reg       <= 1'b0;
      neg_r_reg       <= 1'b0;
      zero_reg        <= 1'b0;
      ovf_reg         <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            dvd_orig_reg <= dividend;
            work_reg     <= (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs_reg      <= (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            neg_q_reg    <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_reg    <= signed_op && dividend[WIDTH-1];
            zero_reg     <= (divisor == '0);
            ovf_reg      <= signed_op && (dividend == MIN_NEG) && (&divisor);
          end
        end
        RUN: begin
          rem_reg  <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          work_reg <= {work_reg[WIDTH-2:0], ~borrow};
          cnt_reg  <= cnt_reg + CW'(1);
        end
        FIX: begin
          if (zero_reg) begin
            quotient_reg  <= '1;
            remainder_reg <= dvd_orig_reg;
          end else begin
            quotient_reg  <= neg_q_reg ? -work_reg : work_reg;
            remainder_reg <= neg_r_reg ? -rem_reg  : rem_reg;
          end
          div_by_zero_reg <= zero_reg;
          overflow_reg    <= ovf_reg;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg == RUN) || (state_reg == FIX);
  assign done        = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = div_by_zero_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_seq_divider_32.sv
// Randomized self-checking bench for seq_divider_32 against an arithmetic
// reference model, plus directed corner cases and reset abort.
module tb_seq_divider_32;

  logic        clk = 1'b0;
  logic        rst_n, start, signed_op;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  logic [31:0] prev_q, prev_r;

  seq_divider_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output logic ov);
    longint sa, sb, sq, sr;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; ov = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q = sq[31:0];
      r = sr[31:0];
    end
  endfunction

  // Runs one operation; inject_at>0 pulses start with junk operands at that edge
  // after the start edge. keep_start leaves start high throughout.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, input bit keep_start);
    logic [31:0] eq, er;
    logic edz, eov;
    int cycles;
    int dones;
    model(s, a, b, eq, er, edz, eov);
    @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    cycles = 0;
    dones = 0;
    while (!done && cycles < 40) begin
      if (inject_at > 0 && cycles + 1 == inject_at) begin
        start = 1'b1; signed_op = ~s; dividend = $urandom; divisor = $urandom;
      end else if (!keep_start) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      if (cycles == 16) check("hold_quotient", 64'(quotient), 64'(prev_q));
    end
    if (!keep_start) start = 1'b0;
    check("latency", 64'(cycles), 64'd33);
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("div_by_zero", 64'(div_by_zero), 64'(edz));
    check("overflow", 64'(overflow), 64'(eov));
    $display("op s=%0d 0x%08h / 0x%08h -> q=0x%08h r=0x%08h dz=%0d ov=%0d lat=%0d",
             s, a, b, quotient, remainder, div_by_zero, overflow, cycles);
    prev_q = eq;
    prev_r = er;
    @(posedge clk); #1;
    check("done_pulse_end", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    check("result_hold", 64'(remainder), 64'(prev_r));
  endtask

  initial begin
    logic s;
    logic [31:0] a, b;
    int sel;
    int cycles;
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    prev_q = '0; prev_r = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_ov", 64'(overflow), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op(1'b0, 32'h0000_1234, 32'd0, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'd1, 0, 1'b0);
    run_op(1'b0, 32'd100, 32'd7, 5, 1'b0);

    // start held high: second operation begins on the first IDLE edge after DONE
    run_op(1'b0, 32'd1000, 32'd9, 0, 1'b1);
    run_op(1'b0, 32'd1000, 32'd9, 0, 1'b1);
    start = 1'b0;

    // reset mid-operation, with start held high during the reset edge
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_q", 64'(quotient), 64'd0);
    check("abort_r", 64'(remainder), 64'd0);
    check("abort_flags", 64'({div_by_zero, overflow}), 64'd0);
    start = 1'b0; rst_n = 1'b1;
    cycles = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) cycles++;
    end
    check("abort_no_done", 64'(cycles), 64'd0);
    prev_q = '0; prev_r = '0;
    run_op(1'b0, 32'd9, 32'd3, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: b = 32'($urandom_range(1, 20));
        4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        5: b = a >> $urandom_range(1, 31);
        default: b = $urandom;
      endcase
      run_op(s, a, b, (sel == 7) ? int'($urandom_range(1, 32)) : 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider_32.md
SEQ_DIVIDER_32 -- requirements
Module: seq_divider_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; all behaviour below is required at 32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port signed_op  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
REQ-006 SHALL have port dividend  input  WIDTH  numerator; sampled with start.
REQ-007 SHALL have port divisor  input  WIDTH  denominator; sampled with start.
REQ-008 SHALL have port busy  output  1  high in RUN and FIX states.
REQ-009 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have port quotient  output  WIDTH  result quotient.
REQ-011 SHALL have port remainder  output  WIDTH  result remainder.
REQ-012 SHALL have port div_by_zero  output  1  last operation had divisor == 0.
REQ-013 SHALL have port overflow  output  1  last operation was signed MIN / -1.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIX, DONE; restoring shift-subtract algorithm, one quotient bit per RUN cycle.
REQ-015 IDLE: start=1 at edge k SHALL register operands and signed_op, take magnitudes if signed, clear iteration counter, go RUN.
REQ-016 RUN: each edge SHALL shift partial remainder left 1 bit, bring in next dividend MSB, subtract divisor magnitude via WIDTH+1-bit subtract; non-negative result -> keep, quotient bit 1; else restore, bit 0.
REQ-017 After the WIDTH-th iteration (edge k+WIDTH) SHALL go FIX.
REQ-018 FIX (edge k+WIDTH+1): SHALL apply signs, update quotient/remainder/flags, go DONE; done=1 during the following cycle only.
REQ-019 DONE: next edge SHALL return to IDLE; done=0; total start-edge-to-done latency WIDTH+1 edges, identical for all operand values.
REQ-020 Signed: quotient SHALL truncate toward zero; negated when operand signs differ; remainder SHALL take dividend's sign; |remainder| < |divisor|.
REQ-021 Divisor 0 (either mode): quotient SHALL be all ones, remainder = dividend unmodified, div_by_zero=1, overflow=0.
REQ-022 Signed dividend 0x80000000 with divisor 0xFFFFFFFF: quotient SHALL be 0x80000000, remainder 0, overflow=1, div_by_zero=0.
REQ-023 Magnitude of 0x80000000 SHALL be handled as unsigned 2^31 (no intermediate overflow).
REQ-024 start while busy or in DONE SHALL be ignored; operands in flight SHALL not change.
REQ-025 quotient, remainder, div_by_zero, overflow SHALL update only in FIX and hold until the next FIX.
REQ-026 start held high continuously SHALL begin a new operation on the first IDLE edge after DONE.

Reset
REQ-027 rst_n=0 at any edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, counter=0.
REQ-028 Reset asserted mid-operation SHALL abort it with no done pulse; start is ignored on any edge where rst_n=0.

Verification
REQ-029 Unsigned 100 / 7 -> done exactly 33 edges after start edge; quotient 14, remainder 2, flags 0.
REQ-030 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-031 Unsigned 0x1234 / 0 -> quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero=1, same latency.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow=1.
REQ-033 start pulsed with new operands at edge k+5 of a running 100 / 7 -> ignored; result still 14 r 2; single done pulse.
REQ-034 rst_n=0 for one edge at edge k+10 -> busy=0, all outputs 0, no done pulse; subsequent 9 / 3 -> quotient 3, remainder 0.
